zdos_trap: RTL
==============

# zdos_trap

Parametrised DOS-mode and floppy-controller trap block for the Z80 side of the base configuration. It tracks the `dos` ROM-select signal and detects CPU accesses to emulated VG93 registers on emulated drives. On a detected access it switches the CPU into the emulation RAM page and captures which register, drive and direction caused the trap. It sits between the port decoder (`vg_rdwr_fclk`, `vg_a`, drive select) and the memory mapper (`in_trdemu`, `trdemu_wr_disable`).

## Interface
Parameters:
- NDRV, 4, number of floppy drives; drive select width is `$clog2(NDRV)`.
- NREG, 4, number of VG register addresses; register index width is `$clog2(NREG)`.
- TMO_W, 16, width of the emulation watchdog counter.

Ports:
- fclk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpm_n  in  1  active-low CP/M force; drives `dos` to 1.
- dos_turn_on, dos_turn_off  in  1  single-cycle DOS enable/disable strobes.
- romnram  in  1  1 = CPU is executing from ROM.
- zpos, m1_n  in  1  zero-position fetch qualifier and M1 cycle.
- vg_rdwr_fclk  in  1  single-cycle strobe: CPU read/write of a VG port.
- vg_wr  in  1  direction of that access (1 = write).
- vg_a  in  $clog2(NREG)  VG register index of the access.
- drv_sel  in  $clog2(NDRV)  currently selected drive.
- reg_mask  in  NREG  1 = register is emulated.
- drv_mask  in  NDRV  1 = drive is emulated.
- clr_nmi  in  1  emulation exit strobe (write to port #BE).
- tmo_limit  in  TMO_W  watchdog limit, in fclk cycles.
- dos  out  1  DOS ROM active.
- in_trdemu  out  1  emulation RAM page mapped.
- trdemu_wr_disable  out  1  write-protect for the emulation page.
- trap_reg  out  $clog2(NREG)  captured `vg_a`.
- trap_drv  out  $clog2(NDRV)  captured `drv_sel`.
- trap_wr  out  1  captured `vg_wr`.
- trap_ovr  out  1  sticky flag: a trap occurred during emulation.
- trap_tmo  out  1  sticky flag: emulation ended by the watchdog.

## Operation
- Reset values:
  - `dos` = 1.
  - All other outputs = 0.
  - State = IDLE; watchdog counter = 0.
- `dos` register, evaluated each cycle in priority order:
  1. `!cpm_n` sets `dos` to 1.
  2. Otherwise `dos_turn_off` clears it to 0.
  3. Otherwise `dos_turn_on` sets it to 1.
- Trap condition: `trap = vg_rdwr_fclk & reg_mask[vg_a] & drv_mask[drv_sel] & dos & romnram`. Out-of-range `drv_sel` (≥ NDRV) never traps.
- States:
  - IDLE: `in_trdemu` = 0, `trdemu_wr_disable` = 0.
  - LOCK: `in_trdemu` = 1, `trdemu_wr_disable` = 1.
  - EMU: `in_trdemu` = 1, `trdemu_wr_disable` = 0.
- Transitions; when several apply, priority is clr_nmi > timeout > trap > unlock:
  - IDLE, on trap → LOCK. Captures `trap_reg`, `trap_drv` and `trap_wr`; clears `trap_tmo`; sets watchdog counter to 0.
  - LOCK, on `zpos & !m1_n` → EMU.
  - LOCK or EMU, on `clr_nmi` → IDLE. Clears `trap_ovr`. Capture registers hold their values.
  - LOCK or EMU, on trap → state unchanged; capture registers unchanged; sets `trap_ovr`.
  - `clr_nmi` in IDLE has no effect.
- Capture outputs stay valid until the next IDLE→LOCK entry.

## Timing
- Trap at edge N: `in_trdemu`, `trdemu_wr_disable` and the capture registers are all valid after edge N. Latency is 1 cycle.
- `zpos & !m1_n` sampled at edge M: `trdemu_wr_disable` drops after edge M.
- `clr_nmi` and a trap in the same cycle while in IDLE: the trap wins and the block enters LOCK.
- `clr_nmi` and a trap in the same cycle while in LOCK or EMU: the block goes to IDLE and `trap_ovr` ends at 0.
- `dos_turn_off` and a trap in the same cycle: the trap is still taken, because the trap condition uses the registered `dos`.
- Asserting `rst_n` mid-emulation returns the block to IDLE and all outputs to their reset values immediately, without waiting for a clock.

## Configuration
- `ZDOS_TRAP_TIMEOUT_EN` defined:
  - The watchdog counter increments every cycle in LOCK or EMU and saturates at all-ones.
  - When counter == `tmo_limit` and `clr_nmi` is low, the block goes to IDLE and sets `trap_tmo`.
  - `tmo_limit` = 0 disables the watchdog.
- `ZDOS_TRAP_TIMEOUT_EN` undefined: no counter is built, `trap_tmo` is tied to 0, and `tmo_limit` is ignored.

## Test plan
- Reset, then `cpm_n`=0 for 1 cycle together with `dos_turn_off`=1 → `dos` stays 1. Then `dos_turn_off` alone → `dos`=0.
- `dos`=1, `romnram`=1, `reg_mask`=4'b1000, `drv_mask`=4'b0010, `drv_sel`=1, `vg_a`=3, `vg_wr`=1, strobe → next cycle `in_trdemu`=1, `trdemu_wr_disable`=1, `trap_reg`=3, `trap_drv`=1, `trap_wr`=1. Repeat with `drv_sel`=0 → no trap.
- In LOCK, `m1_n`=0 with `zpos`=0 → write-disable stays 1. Then `zpos`=1 → it drops; `in_trdemu` stays 1.
- In EMU, second trap → `trap_ovr`=1 and captures unchanged. Then `clr_nmi` → IDLE with `trap_ovr`=0.
- With `ZDOS_TRAP_TIMEOUT_EN` defined and `tmo_limit`=10: trap, no `clr_nmi` → `in_trdemu` falls 11 cycles after entry and `trap_tmo`=1. A new trap clears `trap_tmo`.
- `rst_n` pulsed low while in LOCK → all outputs at reset values before the next fclk edge.

Source files
------------

// File: rtl/zdos_trap.sv
// zdos_trap: DOS ROM-select tracking and VG93 register trap into the emulation RAM page.
// Optional feature macro: ZDOS_TRAP_TIMEOUT_EN (emulation watchdog).
// Ports:
//   fclk, rst_n                     clock, async active-low reset
//   cpm_n, dos_turn_on/off          dos register control (cpm_n has top priority)
//   romnram, zpos, m1_n             ROM execution flag, unlock fetch qualifiers
//   vg_rdwr_fclk, vg_wr, vg_a       VG port access strobe, direction, register index
//   drv_sel, reg_mask, drv_mask     selected drive, emulated register/drive masks
//   clr_nmi, tmo_limit              emulation exit strobe, watchdog limit (0 = off)
//   dos, in_trdemu,
//   trdemu_wr_disable               mapper controls
//   trap_reg, trap_drv, trap_wr     captured access of the trap that entered emulation
//   trap_ovr, trap_tmo              sticky nested-trap and watchdog-exit flags
module zdos_trap #(
    parameter int NDRV  = 4,
    parameter int NREG  = 4,
    parameter int TMO_W = 16
) (
    input  logic                    fclk,
    input  logic                    rst_n,
    input  logic                    cpm_n,
    input  logic                    dos_turn_on,
    input  logic                    dos_turn_off,
    input  logic                    romnram,
    input  logic                    zpos,
    input  logic                    m1_n,
    input  logic                    vg_rdwr_fclk,
    input  logic                    vg_wr,
    input  logic [$clog2(NREG)-1:0] vg_a,
    input  logic [$clog2(NDRV)-1:0] drv_sel,
    input  logic [NREG-1:0]         reg_mask,
    input  logic [NDRV-1:0]         drv_mask,
    input  logic                    clr_nmi,
    input  logic [TMO_W-1:0]        tmo_limit,
    output logic                    dos,
    output logic                    in_trdemu,
    output logic                    trdemu_wr_disable,
    output logic [$clog2(NREG)-1:0] trap_reg,
    output logic [$clog2(NDRV)-1:0] trap_drv,
    output logic                    trap_wr,
    output logic                    trap_ovr,
    output logic                    trap_tmo
);
    localparam int RW    = $clog2(NREG);
    localparam int DW    = $clog2(NDRV);
    localparam int REG_X = 1 << RW;
    localparam int DRV_X = 1 << DW;

    typedef enum logic [1:0] {IDLE, LOCK, EMU} state_t;

    state_t          r_state;
    logic            r_dos;
    logic            r_in_trdemu;
    logic            r_wr_dis;
    logic [RW-1:0]   r_trap_reg;
    logic [DW-1:0]   r_trap_drv;
    logic            r_trap_wr;
    logic            r_trap_ovr;
    logic            w_trap;
    logic            w_tmo;
    logic [REG_X-1:0] w_reg_x;
    logic [DRV_X-1:0] w_drv_x;

    // Masks zero-extended to the full index range so out-of-range selects read 0
    assign w_reg_x = REG_X'(reg_mask);
    assign w_drv_x = DRV_X'(drv_mask);
    // Registered dos is used, so a same-cycle dos_turn_off cannot cancel a trap
    assign w_trap  = vg_rdwr_fclk & w_reg_x[vg_a] & w_drv_x[drv_sel] & r_dos & romnram;

`ifdef ZDOS_TRAP_TIMEOUT_EN
    logic [TMO_W-1:0] r_cnt;
    logic             r_trap_tmo;
    assign w_tmo    = (tmo_limit != '0) && (r_cnt == tmo_limit);
    assign trap_tmo = r_trap_tmo;
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_trap_tmo <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_trap) begin
                r_cnt      <= '0;
                r_trap_tmo <= 1'b0;
            end
        end else begin
            if (!clr_nmi && w_tmo) r_trap_tmo <= 1'b1;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^tmo_limit;
    assign w_tmo        = 1'b0;
    assign trap_tmo     = 1'b0;
`endif

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dos       <= 1'b1;
            r_in_trdemu <= 1'b0;
            r_wr_dis    <= 1'b0;
            r_trap_reg  <= '0;
            r_trap_drv  <= '0;
            r_trap_wr   <= 1'b0;
            r_trap_ovr  <= 1'b0;
        end else begin
            r_dos <= !cpm_n ? 1'b1 : dos_turn_off ? 1'b0 : dos_turn_on ? 1'b1 : r_dos;
            if (r_state == IDLE) begin
                if (w_trap) begin
                    r_state     <= LOCK;
                    r_in_trdemu <= 1'b1;
                    r_wr_dis    <= 1'b1;
                    r_trap_reg  <= vg_a;
                    r_trap_drv  <= drv_sel;
                    r_trap_wr   <= vg_wr;
                end
            end else if (clr_nmi) begin
                r_state     <= IDLE;
                r_in_trdemu <= 1'b0;
                r_wr_dis    <= 1'b0;
                r_trap_ovr  <= 1'b0;
            end else if (w_tmo) begin
                r_state     <= IDLE;
                r_in_trdemu <= 1'b0;
                r_wr_dis    <= 1'b0;
            end else if (w_trap) begin
                r_trap_ovr <= 1'b1;
            end else if (r_state == LOCK && zpos && !m1_n) begin
                r_state  <= EMU;
                r_wr_dis <= 1'b0;
            end
        end
    end

    assign dos               = r_dos;
    assign in_trdemu         = r_in_trdemu;
    assign trdemu_wr_disable = r_wr_dis;
    assign trap_reg          = r_trap_reg;
    assign trap_drv          = r_trap_drv;
    assign trap_wr           = r_trap_wr;
    assign trap_ovr          = r_trap_ovr;
endmodule
